// File: rtl/cpu_mem_pkg.sv
// Shared types and widths for the CPU memory controller slice.
// Imported by the interface, the array and the controller.
package cpu_mem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam logic [ADDR_W-1:0] IO_ADDR_DEF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_ctrl_if.sv
// CPU-side request bus of the memory controller.
// The CPU holds req_en until it sees served.
interface mem_ctrl_if;
  import cpu_mem_pkg::*;

  logic              req_en;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              served;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req_en, req_we, req_addr, req_wdata,
    input  served, rdata
  );

  modport slave (
    input  req_en, req_we, req_addr, req_wdata,
    output served, rdata
  );

endinterface

// File: rtl/mem_ctrl_array.sv
// 256x16 storage with one synchronous write and one synchronous read port.
// Only the read register is reset; the array contents are not.
module mem_array
  import cpu_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mem_ctrl.sv
// Wait-state memory controller: CPU request FSM, program-load port,
// memory-mapped output register and load-vs-CPU write arbitration.
module mem_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int                WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] IO_ADDR     = IO_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  mem_ctrl_if.slave         bus,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] io_out
);

  localparam logic [7:0] WAIT_LD = 8'(WAIT_CYCLES);

  state_t            state;
  req_t              lat;
  req_t              cur;
  logic [7:0]        cnt;
  logic              served_q;
  logic              rd_io;
  logic [DATA_W-1:0] io_snap;
  logic [DATA_W-1:0] arr_rdata;

  logic              relatch;
  logic              enter_done;
  logic              arr_we;
  logic              arr_re;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata;

  // With zero wait states the request commits straight from the bus.
  always_comb begin
    cur = lat;
    if (state == IDLE) begin
      cur.we    = bus.req_we;
      cur.addr  = bus.req_addr;
      cur.wdata = bus.req_wdata;
    end
    relatch = (bus.req_addr != lat.addr) || (bus.req_we != lat.we);
    enter_done = !rst && !load_en && bus.req_en &&
      (((state == IDLE) && (WAIT_CYCLES == 0)) ||
       ((state == WAIT) && !relatch && (cnt == 8'd1)));
    arr_we    = !rst && (load_en || (enter_done && cur.we));
    arr_waddr = load_en ? load_addr : cur.addr;
    arr_wdata = load_en ? load_data : cur.wdata;
    arr_re    = enter_done && !cur.we && (cur.addr != IO_ADDR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lat      <= '0;
      cnt      <= '0;
      served_q <= 1'b0;
      rd_io    <= 1'b0;
      io_snap  <= '0;
      io_out   <= '0;
    end else if (load_en) begin
      state    <= IDLE;
      served_q <= 1'b0;
      if (load_addr == IO_ADDR) io_out <= load_data;
    end else begin
      served_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req_en) begin
            lat      <= cur;
            cnt      <= WAIT_LD;
            state    <= enter_done ? DONE : WAIT;
            served_q <= enter_done;
          end
        end
        WAIT: begin
          if (!bus.req_en) begin
            state <= IDLE;
          end else if (relatch) begin
            lat.we    <= bus.req_we;
            lat.addr  <= bus.req_addr;
            lat.wdata <= bus.req_wdata;
            cnt       <= WAIT_LD;
          end else if (enter_done) begin
            state    <= DONE;
            served_q <= 1'b1;
            cnt      <= cnt - 8'd1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (enter_done && cur.we && (cur.addr == IO_ADDR))
        io_out <= cur.wdata;
      // IO reads are answered from the output register, not the array.
      if (enter_done && !cur.we) begin
        rd_io   <= (cur.addr == IO_ADDR);
        io_snap <= io_out;
      end
    end
  end

  assign bus.served = served_q;
  assign bus.rdata  = rd_io ? io_snap : arr_rdata;

  mem_array u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .re    (arr_re),
    .raddr (cur.addr),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a 2-wait-state build and a 0-wait build
// driven with directed requests; a monitor checks every served pulse.
module tb_mem_ctrl;
  import cpu_mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_ctrl_if b2 ();
  mem_ctrl_if b0 ();

  logic        ld2_en, ld0_en;
  logic [7:0]  ld2_addr, ld0_addr;
  logic [15:0] ld2_data, ld0_data;
  logic [15:0] io2, io0;

  mem_ctrl #(.WAIT_CYCLES(2), .IO_ADDR(8'hFF)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (b2),
    .load_en   (ld2_en),
    .load_addr (ld2_addr),
    .load_data (ld2_data),
    .io_out    (io2)
  );

  mem_ctrl #(.WAIT_CYCLES(0), .IO_ADDR(8'hFF)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .bus       (b0),
    .load_en   (ld0_en),
    .load_addr (ld0_addr),
    .load_data (ld0_data),
    .io_out    (io0)
  );

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } exp_t;

  exp_t        q2[$];
  exp_t        q0[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] last2 = 16'h0;
  logic [15:0] last0 = 16'h0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)",
               nm, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (b2.served === 1'b1) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL served2_unexpected: got served=1 at cycle %0d, required 0", cyc);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("served2_cycle", cyc, e.cyc);
        chk("served2_rdata", {16'h0, b2.rdata}, {16'h0, e.data});
      end
    end
  end

  always @(negedge clk) begin
    if (b0.served === 1'b1) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL served0_unexpected: got served=1 at cycle %0d, required 0", cyc);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("served0_cycle", cyc, e.cyc);
        chk("served0_rdata", {16'h0, b0.rdata}, {16'h0, e.data});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic srv(input bit d0);
    return d0 ? b0.served : b2.served;
  endfunction

  task automatic start(input bit d0, input logic we, input logic [7:0] a,
                       input logic [15:0] d);
    if (d0) begin
      b0.req_en = 1'b1; b0.req_we = we; b0.req_addr = a; b0.req_wdata = d;
    end else begin
      b2.req_en = 1'b1; b2.req_we = we; b2.req_addr = a; b2.req_wdata = d;
    end
  endtask

  task automatic push(input bit d0, input int c, input logic [15:0] d);
    exp_t e;
    e.cyc  = c;
    e.data = d;
    if (d0) q0.push_back(e);
    else    q2.push_back(e);
  endtask

  task automatic finish_req(input bit d0);
    int n = 0;
    do begin
      tick();
      n++;
    end while (srv(d0) !== 1'b1 && n < 20);
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL served_timeout: got no served in 20 cycles, required a pulse");
    end
    if (d0) b0.req_en = 1'b0;
    else    b2.req_en = 1'b0;
    tick();
  endtask

  task automatic rd(input bit d0, input logic [7:0] a, input logic [15:0] d);
    start(d0, 1'b0, a, 16'h0);
    push(d0, cyc + 1 + (d0 ? 0 : 2), d);
    if (d0) last0 = d;
    else    last2 = d;
    finish_req(d0);
  endtask

  task automatic wr(input bit d0, input logic [7:0] a, input logic [15:0] d);
    start(d0, 1'b1, a, d);
    push(d0, cyc + 1 + (d0 ? 0 : 2), d0 ? last0 : last2);
    finish_req(d0);
  endtask

  task automatic load(input bit d0, input logic [7:0] a, input logic [15:0] d);
    if (d0) begin
      ld0_en = 1'b1; ld0_addr = a; ld0_data = d;
    end else begin
      ld2_en = 1'b1; ld2_addr = a; ld2_data = d;
    end
    tick();
    ld0_en = 1'b0;
    ld2_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100us, required completion");
    $fatal(1);
  end

  initial begin
    b2.req_en = 0; b2.req_we = 0; b2.req_addr = 0; b2.req_wdata = 0;
    b0.req_en = 0; b0.req_we = 0; b0.req_addr = 0; b0.req_wdata = 0;
    ld2_en = 0; ld2_addr = 0; ld2_data = 0;
    ld0_en = 0; ld0_addr = 0; ld0_data = 0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_served2", {31'h0, b2.served}, 32'h0);
    chk("rst_rdata2", {16'h0, b2.rdata}, 32'h0);
    chk("rst_io2", {16'h0, io2}, 32'h0);
    chk("rst_served0", {31'h0, b0.served}, 32'h0);
    chk("rst_rdata0", {16'h0, b0.rdata}, 32'h0);
    chk("rst_io0", {16'h0, io0}, 32'h0);

    load(0, 8'h10, 16'hBEEF);
    load(0, 8'h20, 16'h2020);
    load(0, 8'h21, 16'h2121);
    load(0, 8'h30, 16'h3030);
    load(0, 8'h40, 16'h4040);
    load(0, 8'h50, 16'h5555);
    load(0, 8'h51, 16'h5050);

    rd(0, 8'h10, 16'hBEEF);
    wr(0, 8'hFF, 16'h0FB1);
    chk("io_write", {16'h0, io2}, 32'h0FB1);
    rd(0, 8'hFF, 16'h0FB1);

    // address change one cycle into WAIT restarts the wait
    start(0, 1'b0, 8'h20, 16'h0);
    tick();
    start(0, 1'b0, 8'h21, 16'h0);
    push(0, cyc + 3, 16'h2121);
    last2 = 16'h2121;
    finish_req(0);

    start(0, 1'b1, 8'h30, 16'hDEAD);
    tick();
    b2.req_en = 1'b0;
    tick();
    tick();
    tick();
    rd(0, 8'h30, 16'h3030);

    start(0, 1'b1, 8'h40, 16'h1234);
    tick();
    load(0, 8'h40, 16'h4141);
    chk("load_served", {31'h0, b2.served}, 32'h0);
    b2.req_en = 1'b0;
    tick();
    rd(0, 8'h40, 16'h4141);

    // load lands on the edge that would have entered DONE
    start(0, 1'b1, 8'h50, 16'h9999);
    tick();
    tick();
    load(0, 8'h51, 16'h5151);
    b2.req_en = 1'b0;
    tick();
    rd(0, 8'h50, 16'h5555);
    rd(0, 8'h51, 16'h5151);

    start(0, 1'b1, 8'hFF, 16'h7777);
    tick();
    rst = 1'b1;
    b2.req_en = 1'b0;
    tick();
    rst = 1'b0;
    chk("rstw_served", {31'h0, b2.served}, 32'h0);
    chk("rstw_rdata", {16'h0, b2.rdata}, 32'h0);
    chk("rstw_io", {16'h0, io2}, 32'h0);
    last2 = 16'h0;
    last0 = 16'h0;
    rd(0, 8'hFF, 16'h0000);
    rd(0, 8'h10, 16'hBEEF);

    load(1, 8'h05, 16'h0505);
    rd(1, 8'h05, 16'h0505);
    wr(1, 8'h06, 16'hABCD);
    rd(1, 8'h06, 16'hABCD);
    wr(1, 8'hFF, 16'h00AA);
    chk("io0_write", {16'h0, io0}, 32'h00AA);
    rd(1, 8'hFF, 16'h00AA);

    tick();
    tick();
    tick();
    chk("pending2", q2.size(), 32'h0);
    chk("pending0", q0.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
